ru_wb_arbiter: RTL and testbench

RU_WB_ARBITER -- requirements
Module: ru_wb_arbiter

---
 rtl/ru_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_ru_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ru_wb_arbiter.sv
// ru_wb_arbiter: arbitrates two writeback requesters (ALU = A, LSU = B) onto a
// single register-unit write port. After reset an optional sweep writes x1..x31
// (x2 gets SP_INIT, the rest 0) before requesters are served. Grants are
// round-robin when both requesters are valid; the write appears one cycle after
// acceptance. Writes to x0 are accepted but dropped.
module ru_wb_arbiter #(
  parameter logic [31:0] SP_INIT = 32'hFFFF_FFFF,
  parameter logic        INIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [4:0]  rd,
  output logic [31:0] DataWr,
  output logic        RUWr,
  output logic        init_done,
  output logic        conflict
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_EN == 1'b1) ? ST_INIT : ST_RUN;

  state_t      state_r, state_s;
  logic [4:0]  idx_r, idx_s;
  logic        ptr_r, ptr_s;        // 0: A wins a tie, 1: B wins a tie
  logic [4:0]  rd_r, rd_s;
  logic [31:0] data_r, data_s;
  logic        wr_r, wr_s;
  logic        done_r, done_s;
  logic        conf_r, conf_s;

  logic        serve_s;
  logic        both_s;
  logic        a_grant_s;
  logic        b_grant_s;

  // Requesters are only served once init_done is visible; this also keeps
  // ready low while reset is held, since done_r is cleared asynchronously.
  assign serve_s   = done_r && (state_r == ST_RUN);
  assign both_s    = a_valid && b_valid;
  assign a_grant_s = serve_s && a_valid && (!b_valid || (ptr_r == 1'b0));
  assign b_grant_s = serve_s && b_valid && !a_grant_s;

  assign a_ready   = a_grant_s;
  assign b_ready   = b_grant_s;

  assign rd        = rd_r;
  assign DataWr    = data_r;
  assign RUWr      = wr_r;
  assign init_done = done_r;
  assign conflict  = conf_r;

  // Next-state and next-output logic for the INIT sweep and RUN arbitration.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    ptr_s   = ptr_r;
    rd_s    = 5'd0;
    data_s  = 32'd0;
    wr_s    = 1'b0;
    done_s  = done_r;
    conf_s  = 1'b0;

    case (state_r)
      ST_INIT: begin
        wr_s   = 1'b1;
        rd_s   = idx_r;
        data_s = (idx_r == 5'd2) ? SP_INIT : 32'd0;
        idx_s  = idx_r + 5'd1;
        if (idx_r == 5'd31) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end

      ST_RUN: begin
        done_s = 1'b1;
        if (a_grant_s) begin
          wr_s   = (a_rd != 5'd0);
          rd_s   = a_rd;
          data_s = (a_rd != 5'd0) ? a_data : 32'd0;
        end else if (b_grant_s) begin
          wr_s   = (b_rd != 5'd0);
          rd_s   = b_rd;
          data_s = (b_rd != 5'd0) ? b_data : 32'd0;
        end else begin
          wr_s   = 1'b0;
        end

        // After a tie the loser gets priority next time.
        if (serve_s && both_s) begin
          ptr_s = ~ptr_r;
        end else begin
          ptr_s = ptr_r;
        end

        conf_s = serve_s && both_s && (a_rd == b_rd) && (a_rd != 5'd0);
      end

      default: begin
        state_s = RST_STATE;
        idx_s   = 5'd1;
        ptr_s   = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State, sweep index, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
      idx_r   <= 5'd1;
      ptr_r   <= 1'b0;
      rd_r    <= 5'd0;
      data_r  <= 32'd0;
      wr_r    <= 1'b0;
      done_r  <= 1'b0;
      conf_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      ptr_r   <= ptr_s;
      rd_r    <= rd_s;
      data_r  <= data_s;
      wr_r    <= wr_s;
      done_r  <= done_s;
      conf_r  <= conf_s;
    end
  end

endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Self-checking bench for ru_wb_arbiter: directed init / reset / arbitration
// steps followed by randomized held requests checked against a per-cycle
// reference model of the grant and writeback rules.
module tb_ru_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;

  logic        a_ready, b_ready, RUWr, init_done, conflict;
  logic [4:0]  rd;
  logic [31:0] DataWr;

  logic        a_ready_2, b_ready_2, RUWr_2, init_done_2, conflict_2;
  logic [4:0]  rd_2;
  logic [31:0] DataWr_2;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_ptr;           // 0: A wins next tie
  logic [31:0] rf_dut [32];     // register file as written by the DUT

  ru_wb_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rd(rd), .DataWr(DataWr), .RUWr(RUWr), .init_done(init_done), .conflict(conflict)
  );

  ru_wb_arbiter #(.INIT_EN(1'b0)) u_noinit (
    .clk(clk), .rst_n(rst2_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready_2),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready_2),
    .rd(rd_2), .DataWr(DataWr_2), .RUWr(RUWr_2), .init_done(init_done_2), .conflict(conflict_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    chk(tag, {31'd0, obs}, {31'd0, expv});
  endtask

  // One INIT-sweep cycle: write of x<k>, requesters blocked.
  task automatic chk_init(input int k);
    logic [4:0]  ek;
    logic [31:0] ed;
    ek = 5'(k);
    ed = (k == 2) ? 32'hFFFF_FFFF : 32'd0;
    chk("init_rd", {27'd0, rd}, {27'd0, ek});
    chk("init_data", DataWr, ed);
    chk1("init_wr", RUWr, 1'b1);
    chk1("init_done_low", init_done, 1'b0);
    chk1("init_a_ready", a_ready, 1'b0);
  endtask

  // One RUN cycle: drive requests, check ready against the model, then check
  // the registered write that follows the edge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       output logic a_acc, output logic b_acc);
    logic        a_go, b_go, e_wr, e_conf;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #1;
    if (av && bv) begin
      a_go = (m_ptr == 1'b0);
      b_go = !a_go;
      m_ptr = a_go;            // loser gets the next tie
    end else begin
      a_go = av;
      b_go = bv;
    end
    chk1("a_ready", a_ready, a_go);
    chk1("b_ready", b_ready, b_go);
    e_rd = a_go ? ard : (b_go ? brd : 5'd0);
    e_data = a_go ? ad : (b_go ? bd : 32'd0);
    e_wr = (e_rd != 5'd0);
    if (!e_wr) e_data = 32'd0;
    e_conf = av && bv && (ard == brd) && (ard != 5'd0);
    @(posedge clk); #1;
    chk1("RUWr", RUWr, e_wr);
    chk("rd", {27'd0, rd}, {27'd0, e_rd});
    chk("DataWr", DataWr, e_data);
    chk1("conflict", conflict, e_conf);
    chk1("init_done", init_done, 1'b1);
    if (RUWr) rf_dut[rd] = DataWr;
    a_acc = a_go;
    b_acc = b_go;
  endtask

  initial begin
    logic        acc_a, acc_b;
    logic        pa, pb;
    logic [4:0]  ra, rb;
    logic [31:0] da, db;

    for (int i = 0; i < 32; i++) rf_dut[i] = 32'd0;
    m_ptr = 1'b0;

    // Reset state, with requests present.
    rst_n = 1'b0; rst2_n = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h2222_2222;
    #12;
    chk1("rst_RUWr", RUWr, 1'b0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_DataWr", DataWr, 32'd0);
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_conflict", conflict, 1'b0);
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_b_ready", b_ready, 1'b0);
    chk1("rst_a_ready_noinit", a_ready_2, 1'b0);
    chk1("rst_init_done_noinit", init_done_2, 1'b0);

    // Release both; the INIT_EN=0 instance is done after the first edge.
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;
    chk1("noinit_done", init_done_2, 1'b1);
    chk1("noinit_no_write", RUWr_2, 1'b0);
    chk_init(1);
    rst2_n = 1'b0;

    // Request from A during the sweep; abort the sweep at index 10.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hA5A5_A5A5;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      chk_init(k);
    end
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_RUWr", RUWr, 1'b0);
    chk("abort_rd", {27'd0, rd}, 32'd0);
    chk("abort_DataWr", DataWr, 32'd0);
    chk1("abort_a_ready", a_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Full sweep restarting at x1, A still requesting.
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      chk_init(k);
    end
    @(posedge clk); #1;
    chk1("done_rise", init_done, 1'b1);
    chk1("done_no_write", RUWr, 1'b0);

    // Held A request now served: x5 = A5A5A5A5.
    m_ptr = 1'b0;
    cycle(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, acc_a, acc_b);

    // Both held 4 cycles: grants A,B,A,B.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd10, 32'h1234_5678, 1'b1, 5'd15, 32'h8765_4321, acc_a, acc_b);
      chk1("rr_grant_a", acc_a, (i % 2) == 0);
    end

    // Write to x0 is accepted and dropped.
    cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, acc_a, acc_b);

    // Equal rd: A first with conflict pulse, then B; x7 ends with B's data.
    cycle(1'b1, 5'd7, 32'hAAAA_0007, 1'b1, 5'd7, 32'hBBBB_0007, acc_a, acc_b);
    chk1("conf_a_first", acc_a, 1'b1);
    cycle(1'b0, 5'd7, 32'hAAAA_0007, 1'b1, 5'd7, 32'hBBBB_0007, acc_a, acc_b);
    chk("x7_final", rf_dut[7], 32'hBBBB_0007);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc_a, acc_b);

    // Randomized held requests.
    pa = 1'b0; pb = 1'b0; ra = 5'd0; rb = 5'd0; da = 32'd0; db = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!pa) begin
        pa = 1'($urandom_range(0, 1));
        ra = 5'($urandom_range(0, 7));
        da = $urandom;
      end
      if (!pb) begin
        pb = 1'($urandom_range(0, 1));
        rb = 5'($urandom_range(0, 7));
        db = $urandom;
      end
      cycle(pa, ra, da, pb, rb, db, acc_a, acc_b);
      if (acc_a) pa = 1'b0;
      if (acc_b) pb = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
